prio_encoder_hs: RTL and testbench

PRIO_ENCODER_HS -- requirements
Module: prio_encoder_hs

---
 rtl/prio_encoder_hs.sv | 105 ++++++++++
 tb/tb_prio_encoder_hs.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/prio_encoder_hs.sv
// prio_encoder_hs: registered priority encoder with a valid/ready handshake
// on both sides.
//
// The search starts at bit ptr and moves downward, wrapping around from
// bit 0 to bit N-1.
//
// Optional feature, macro PRIO_ENCODER_HS_RR_EN:
//   - When defined, ptr becomes a register for round-robin arbitration.
//     After each winner k it is set to k-1, wrapping to N-1 when k is 0.
//   - When undefined, ptr is the constant N-1, which gives fixed
//     MSB-first priority.
module prio_encoder_hs #(
    parameter int N = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req,
    input  logic                 en,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [$clog2(N)-1:0] idx,
    output logic                 any,
    output logic                 out_valid,
    input  logic                 out_ready
);

    localparam int W = $clog2(N);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_FULL = 1'b1
    } state_t;

    state_t         state;
    logic [W-1:0]   ptr;
    logic [W-1:0]   scan_pos;
    logic [W-1:0]   win_idx;
    logic           win_found;
    logic           accept;
    logic           hit;

    assign out_valid = (state == S_FULL);
    assign in_ready  = !out_valid || out_ready;
    assign accept    = in_valid && in_ready;
    assign hit       = en && win_found;

    // Find the first set request while scanning down from ptr.
    // The subtraction wraps modulo N because N is a power of two.
    always_comb begin
        scan_pos  = '0;
        win_idx   = '0;
        win_found = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            scan_pos = ptr - W'(i);
            if (!win_found && req[scan_pos]) begin
                win_found = 1'b1;
                win_idx   = scan_pos;
            end
        end
    end

`ifdef PRIO_ENCODER_HS_RR_EN
    // Round-robin pointer. It moves only when an accepted input produces
    // a winner. At k=0, k-1 wraps to N-1.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '1;
        end else if (accept && hit) begin
            ptr <= win_idx - 1'b1;
        end
    end
`else
    assign ptr = '1;
`endif

    // Handshake state and the registered result.
    // Reset discards any pending result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            idx   <= '0;
            any   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        state <= S_FULL;
                        idx   <= hit ? win_idx : '0;
                        any   <= hit;
                    end
                end
                S_FULL: begin
                    if (accept) begin
                        idx <= hit ? win_idx : '0;
                        any <= hit;
                    end else if (out_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_prio_encoder_hs.sv
// Self-checking bench for prio_encoder_hs with N=8.
// It runs directed scenarios followed by random traffic, and checks every
// cycle against a priority-list reference model.
module tb_prio_encoder_hs;

    localparam int N = 8;
    localparam int W = $clog2(N);

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  req;
    logic          en;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  idx;
    logic          any;
    logic          out_valid;
    logic          out_ready;

    int n_cmp = 0;
    int n_err = 0;

    // reference model state
    bit m_valid;
    int m_idx;
    bit m_any;
    int m_ptr;

    prio_encoder_hs #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .en        (en),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .idx       (idx),
        .any       (any),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Winner search: build the priority order explicitly
    // (ptr, ptr-1, ..., 0, N-1, ..., ptr+1) and take the first requester.
    function automatic int model_winner(input logic [N-1:0] r, input int p);
        int order[$];
        for (int j = p; j >= 0; j--) order.push_back(j);
        for (int j = N - 1; j > p; j--) order.push_back(j);
        foreach (order[q]) if (r[order[q]]) return order[q];
        return -1;
    endfunction

    // One clock cycle: drive inputs, check in_ready, advance the model, then
    // check the outputs.
    task automatic cyc(input logic r_rst, input logic [N-1:0] r_req, input logic r_en,
                       input logic r_iv, input logic r_ordy);
        bit acc;
        int w;
        @(negedge clk);
        rst = r_rst; req = r_req; en = r_en; in_valid = r_iv; out_ready = r_ordy;
        #1;
        check("in_ready", in_ready, (!m_valid || r_ordy));
        @(posedge clk);
        acc = r_iv && (!m_valid || r_ordy);
        if (r_rst) begin
            m_valid = 0; m_idx = 0; m_any = 0; m_ptr = N - 1;
        end else if (acc) begin
            w = model_winner(r_req, m_ptr);
            if (r_en && w >= 0) begin
                m_idx = w; m_any = 1;
`ifdef PRIO_ENCODER_HS_RR_EN
                m_ptr = (w == 0) ? N - 1 : w - 1;
`endif
            end else begin
                m_idx = 0; m_any = 0;
            end
            m_valid = 1;
        end else if (r_ordy) begin
            m_valid = 0;
        end
        #1;
        check("out_valid", out_valid, m_valid);
        check("idx", idx, m_idx);
        check("any", any, m_any);
    endtask

    initial begin
        rst = 1; req = '0; en = 0; in_valid = 0; out_ready = 0;
        m_valid = 0; m_idx = 0; m_any = 0; m_ptr = N - 1;

        // reset state
        cyc(1, '0, 0, 0, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_idx", idx, 0);
        check("rst_any", any, 0);

        // priority
        cyc(0, 8'b0010_1100, 1, 1, 1);
        check("prio_idx", idx, 5);
        check("prio_any", any, 1);
        check("prio_valid", out_valid, 1);

        // zero request and disabled encoder
        cyc(0, 8'h00, 1, 1, 1);
        check("zero_any", any, 0);
        check("zero_valid", out_valid, 1);
        cyc(0, 8'hFF, 0, 1, 1);
        check("dis_idx", idx, 0);
        check("dis_any", any, 0);
        check("dis_valid", out_valid, 1);

        // back-to-back reset so round-robin starts from ptr=N-1
        cyc(1, '0, 0, 0, 0);

        // backpressure
        cyc(0, 8'h08, 1, 1, 1);
        check("bp_load", idx, 3);
        for (int c = 0; c < 4; c++) begin
            cyc(0, 8'h80, 1, 1, 0);
            check("bp_in_ready", in_ready, 0);
            check("bp_hold", idx, 3);
        end
        cyc(0, 8'h80, 1, 1, 1);
        check("bp_release", idx, 7);

        // handoff without a new input clears out_valid
        cyc(0, '0, 0, 0, 1);
        check("drain_valid", out_valid, 0);
        cyc(1, '0, 0, 0, 0);

        // throughput
        cyc(0, 8'h01, 1, 1, 1); check("tp0", idx, 0); check("tp0_v", out_valid, 1);
        cyc(0, 8'h40, 1, 1, 1); check("tp1", idx, 6); check("tp1_v", out_valid, 1);
        cyc(0, 8'h10, 1, 1, 1); check("tp2", idx, 4); check("tp2_v", out_valid, 1);

        // round-robin sweep, or fixed priority in the default build
        cyc(1, '0, 0, 0, 0);
        for (int c = 0; c < 9; c++) begin
            cyc(0, 8'hFF, 1, 1, 1);
`ifdef PRIO_ENCODER_HS_RR_EN
            check("rr_idx", idx, (c == 8) ? 7 : 7 - c);
`else
            check("fixed_idx", idx, 7);
`endif
        end

        // reset while a result is pending
        cyc(1, '0, 0, 0, 0);
        cyc(0, 8'h20, 1, 1, 1);
        cyc(0, 8'h02, 1, 1, 0);
        cyc(1, 8'hFF, 1, 1, 0);
        check("mid_rst_valid", out_valid, 0);
        #1;
        check("mid_rst_in_ready", in_ready, 1);
        cyc(0, 8'h0C, 1, 1, 1);
        check("mid_rst_idx", idx, 3);

        // random traffic
        for (int c = 0; c < 400; c++) begin
            cyc(($urandom_range(0, 39) == 0), N'($urandom),
                ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
                ($urandom_range(0, 2) != 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
